// File: rtl/floo_eject_sink.sv
// floo_eject_sink
// ----------------------------------------------------------------------------
// Terminal sink for the local (Eject) port of a mesh router in filler/dummy
// tiles. Each of NumChan independent valid/ready channels is absorbed, blocked
// or throttled according to mode_i. For every channel the sink tracks packet
// framing and counts accepted flits and packets. It also keeps a rolling data
// signature, so any traffic that reaches the tile can be observed.
//
// Ports
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   valid_i      per-channel flit valid
//   ready_o      per-channel flit ready (combinational from mode/phase only)
//   data_i       per-channel payload, channel c at [c*FlitWidth +: FlitWidth]
//   last_i       per-channel last-flit-of-packet marker
//   mode_i       0=SINK, 1=BLOCK, 2=THROTTLE, 3=treated as BLOCK
//   clear_i      synchronous clear of counters, signatures, framing, phase, ovf
//   flit_cnt_o   accepted flits per channel (saturating)
//   pkt_cnt_o    accepted last-flits per channel (saturating)
//   signature_o  rolling rotate-left/XOR signature per channel
//   busy_o       channel is inside a packet
//   ovf_o        sticky: an accept was attempted with a counter at saturation
// ----------------------------------------------------------------------------
module floo_eject_sink #(
    parameter int unsigned NumChan        = 3,
    parameter int unsigned FlitWidth      = 64,
    parameter int unsigned CntWidth       = 16,
    parameter int unsigned ThrottlePeriod = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NumChan-1:0]            valid_i,
    output logic [NumChan-1:0]            ready_o,
    input  logic [NumChan*FlitWidth-1:0]  data_i,
    input  logic [NumChan-1:0]            last_i,
    input  logic [1:0]                    mode_i,
    input  logic                          clear_i,
    output logic [NumChan*CntWidth-1:0]   flit_cnt_o,
    output logic [NumChan*CntWidth-1:0]   pkt_cnt_o,
    output logic [NumChan*FlitWidth-1:0]  signature_o,
    output logic [NumChan-1:0]            busy_o,
    output logic                          ovf_o
);

    localparam int unsigned PhW = (ThrottlePeriod > 1) ? $clog2(ThrottlePeriod) : 1;
    localparam logic [PhW-1:0] PhaseLast = PhW'(ThrottlePeriod - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_e;

    state_e               r_state      [NumChan];
    state_e               w_state_next [NumChan];
    logic [CntWidth-1:0]  r_flit_cnt   [NumChan];
    logic [CntWidth-1:0]  w_flit_next  [NumChan];
    logic [CntWidth-1:0]  r_pkt_cnt    [NumChan];
    logic [CntWidth-1:0]  w_pkt_next   [NumChan];
    logic [FlitWidth-1:0] r_sig        [NumChan];
    logic [FlitWidth-1:0] w_sig_next   [NumChan];
    logic [PhW-1:0]       r_phase      [NumChan];
    logic [PhW-1:0]       w_phase_next [NumChan];
    logic                 r_ovf;
    logic                 w_ovf_next;
    logic [NumChan-1:0]   w_ready;
    logic [NumChan-1:0]   w_accept;

    // Ready never looks at valid_i. It is forced low while reset is asserted,
    // so nothing can be accepted before the state registers are known.
    always_comb begin
        w_ready = '0;
        for (int c = 0; c < NumChan; c++) begin
            case (mode_i)
                2'd0:    w_ready[c] = rst_ni;
                2'd2:    w_ready[c] = rst_ni & (r_phase[c] == '0);
                default: w_ready[c] = 1'b0;
            endcase
        end
    end

    assign ready_o  = w_ready;
    assign w_accept = valid_i & w_ready;

    // clear_i wins over a coinciding accept. That flit still handshakes but
    // leaves no trace. Counters hold at all-ones and flag ovf instead of wrapping.
    always_comb begin
        w_ovf_next = r_ovf;
        for (int c = 0; c < NumChan; c++) begin
            w_state_next[c] = r_state[c];
            w_flit_next[c]  = r_flit_cnt[c];
            w_pkt_next[c]   = r_pkt_cnt[c];
            w_sig_next[c]   = r_sig[c];
            w_phase_next[c] = (r_phase[c] == PhaseLast) ? '0 : r_phase[c] + 1'b1;

            if (clear_i) begin
                w_state_next[c] = IDLE;
                w_flit_next[c]  = '0;
                w_pkt_next[c]   = '0;
                w_sig_next[c]   = '0;
                w_phase_next[c] = '0;
            end else if (w_accept[c]) begin
                w_state_next[c] = last_i[c] ? IDLE : IN_PKT;

                if (r_flit_cnt[c] == '1) begin
                    w_ovf_next = 1'b1;
                end else begin
                    w_flit_next[c] = r_flit_cnt[c] + 1'b1;
                end

                if (last_i[c]) begin
                    if (r_pkt_cnt[c] == '1) begin
                        w_ovf_next = 1'b1;
                    end else begin
                        w_pkt_next[c] = r_pkt_cnt[c] + 1'b1;
                    end
                end

                w_sig_next[c] = {r_sig[c][FlitWidth-2:0], r_sig[c][FlitWidth-1]}
                              ^ data_i[c*FlitWidth +: FlitWidth];
            end
        end

        if (clear_i) begin
            w_ovf_next = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int c = 0; c < NumChan; c++) begin
                r_state[c]    <= IDLE;
                r_flit_cnt[c] <= '0;
                r_pkt_cnt[c]  <= '0;
                r_sig[c]      <= '0;
                r_phase[c]    <= '0;
            end
            r_ovf <= 1'b0;
        end else begin
            for (int c = 0; c < NumChan; c++) begin
                r_state[c]    <= w_state_next[c];
                r_flit_cnt[c] <= w_flit_next[c];
                r_pkt_cnt[c]  <= w_pkt_next[c];
                r_sig[c]      <= w_sig_next[c];
                r_phase[c]    <= w_phase_next[c];
            end
            r_ovf <= w_ovf_next;
        end
    end

    for (genvar g = 0; g < NumChan; g++) begin : g_out
        assign flit_cnt_o[g*CntWidth +: CntWidth]     = r_flit_cnt[g];
        assign pkt_cnt_o[g*CntWidth +: CntWidth]      = r_pkt_cnt[g];
        assign signature_o[g*FlitWidth +: FlitWidth]  = r_sig[g];
        assign busy_o[g]                              = (r_state[g] == IN_PKT);
    end

    assign ovf_o = r_ovf;

endmodule

// File: tb/tb_floo_eject_sink.sv
// tb_floo_eject_sink
// Directed bench for floo_eject_sink. The main instance uses the default
// parameters. A second instance with CntWidth=2 exercises counter saturation
// and the sticky overflow flag. Inputs change 1 time unit after a rising edge,
// and outputs are sampled there as well.
module tb_floo_eject_sink;

    logic         clk = 1'b0;
    logic         rstN;
    logic [2:0]   valid, last;
    logic [191:0] data;
    logic [1:0]   mode;
    logic         clear;
    logic [2:0]   ready, busy;
    logic [47:0]  flitCnt, pktCnt;
    logic [191:0] signature;
    logic         ovf;

    logic [2:0]   sValid, sLast, sReady, sBusy;
    logic [191:0] sData, sSig;
    logic [1:0]   sMode;
    logic         sClear, sOvf;
    logic [5:0]   sFlit, sPkt;

    int nVec = 0;
    int nErr = 0;

    always #5 clk = ~clk;

    floo_eject_sink dut (
        .clk_i(clk), .rst_ni(rstN), .valid_i(valid), .ready_o(ready),
        .data_i(data), .last_i(last), .mode_i(mode), .clear_i(clear),
        .flit_cnt_o(flitCnt), .pkt_cnt_o(pktCnt), .signature_o(signature),
        .busy_o(busy), .ovf_o(ovf)
    );

    floo_eject_sink #(.CntWidth(2)) dutSat (
        .clk_i(clk), .rst_ni(rstN), .valid_i(sValid), .ready_o(sReady),
        .data_i(sData), .last_i(sLast), .mode_i(sMode), .clear_i(sClear),
        .flit_cnt_o(sFlit), .pkt_cnt_o(sPkt), .signature_o(sSig),
        .busy_o(sBusy), .ovf_o(sOvf)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [2:0] v, input logic [2:0] l,
                                 input logic [1:0] m, input logic c);
        valid = v;
        last  = l;
        mode  = m;
        clear = c;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        nVec++;
        assert (observed === expected) else begin
            nErr++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        rstN = 1'b0; valid = 3'b111; last = 3'b000; mode = 2'd0; clear = 1'b0;
        data = '0;
        sValid = 3'b000; sLast = 3'b000; sMode = 2'd0; sClear = 1'b0; sData = '0;

        // Reset state
        #12;
        checkOutput("rst_ready", 64'(ready), 64'h0);
        checkOutput("rst_flit", 64'(flitCnt), 64'h0);
        checkOutput("rst_pkt", 64'(pktCnt), 64'h0);
        checkOutput("rst_sig0", signature[63:0], 64'h0);
        checkOutput("rst_sig2", signature[191:128], 64'h0);
        checkOutput("rst_busy", 64'(busy), 64'h0);
        checkOutput("rst_ovf", 64'(ovf), 64'h0);
        checkOutput("rst_sat_ready", 64'(sReady), 64'h0);
        rstN = 1'b1;
        #1;
        checkOutput("rel_ready", 64'(ready), 64'h7);
        valid = 3'b000;
        step();
        checkOutput("rel_flit", 64'(flitCnt), 64'h0);

        // SINK, channel 0, 3-flit packet 1,2,4. Signature: 0->1->rotl(1)^2=0->rotl(0)^4=4
        data[63:0] = 64'h1;
        applyStimulus(3'b001, 3'b000, 2'd0, 1'b0);
        step();
        checkOutput("pkt_busy1", 64'(busy), 64'h1);
        checkOutput("pkt_flit1", 64'(flitCnt[15:0]), 64'd1);
        data[63:0] = 64'h2;
        step();
        checkOutput("pkt_busy2", 64'(busy), 64'h1);
        data[63:0] = 64'h4;
        applyStimulus(3'b001, 3'b001, 2'd0, 1'b0);
        step();
        applyStimulus(3'b000, 3'b000, 2'd0, 1'b0);
        checkOutput("pkt_busy3", 64'(busy), 64'h0);
        checkOutput("pkt_flit3", 64'(flitCnt[15:0]), 64'd3);
        checkOutput("pkt_pkt3", 64'(pktCnt[15:0]), 64'd1);
        checkOutput("pkt_sig", signature[63:0], 64'h4);
        checkOutput("pkt_flit_ch1", 64'(flitCnt[31:16]), 64'd0);

        // Clear, then THROTTLE with valid[1] held for 12 cycles
        applyStimulus(3'b000, 3'b000, 2'd0, 1'b1);
        step();
        applyStimulus(3'b010, 3'b000, 2'd2, 1'b0);
        checkOutput("clr_flit0", 64'(flitCnt[15:0]), 64'd0);
        checkOutput("clr_pkt0", 64'(pktCnt[15:0]), 64'd0);
        checkOutput("clr_sig0", signature[63:0], 64'h0);
        for (int k = 0; k < 12; k++) begin
            checkOutput($sformatf("thr_ready_c%0d", k), 64'(ready),
                        (k % 4 == 0) ? 64'h7 : 64'h0);
            step();
        end
        applyStimulus(3'b000, 3'b000, 2'd0, 1'b0);
        checkOutput("thr_flit1", 64'(flitCnt[31:16]), 64'd3);
        checkOutput("thr_pkt1", 64'(pktCnt[31:16]), 64'd0);
        checkOutput("thr_busy", 64'(busy), 64'h2);

        // BLOCK mid-packet on channel 2 (last blocked cycle uses reserved mode 3)
        data[191:128] = 64'h8000_0000_0000_0001;
        applyStimulus(3'b100, 3'b000, 2'd0, 1'b0);
        step();
        checkOutput("blk_busy_start", 64'(busy[2]), 64'h1);
        data[191:128] = 64'h0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(3'b100, 3'b000, (k == 4) ? 2'd3 : 2'd1, 1'b0);
            checkOutput($sformatf("blk_ready_c%0d", k), 64'(ready), 64'h0);
            step();
        end
        checkOutput("blk_flit2_held", 64'(flitCnt[47:32]), 64'd1);
        checkOutput("blk_busy_held", 64'(busy[2]), 64'h1);
        checkOutput("blk_sig2_held", signature[191:128], 64'h8000_0000_0000_0001);
        applyStimulus(3'b100, 3'b100, 2'd0, 1'b0);
        step();
        applyStimulus(3'b000, 3'b000, 2'd0, 1'b0);
        checkOutput("blk_pkt2", 64'(pktCnt[47:32]), 64'd1);
        checkOutput("blk_busy_end", 64'(busy[2]), 64'h0);
        checkOutput("blk_flit2", 64'(flitCnt[47:32]), 64'd2);
        // rotl(0x8000_0000_0000_0001) ^ 0 = 0x3: checks the wrap-around bit
        checkOutput("blk_sig2", signature[191:128], 64'h3);

        // Clear, then one simultaneous single-flit packet on all channels
        applyStimulus(3'b000, 3'b000, 2'd0, 1'b1);
        step();
        applyStimulus(3'b000, 3'b000, 2'd0, 1'b0);
        checkOutput("clr2_busy", 64'(busy), 64'h0);
        checkOutput("clr2_flit", 64'(flitCnt), 64'h0);
        data = {64'h30, 64'h20, 64'h10};
        applyStimulus(3'b111, 3'b111, 2'd0, 1'b0);
        step();
        applyStimulus(3'b000, 3'b000, 2'd0, 1'b0);
        checkOutput("all_flit", 64'(flitCnt), 64'h0001_0001_0001);
        checkOutput("all_pkt", 64'(pktCnt), 64'h0001_0001_0001);
        checkOutput("all_busy", 64'(busy), 64'h0);
        checkOutput("all_sig0", signature[63:0], 64'h10);
        checkOutput("all_sig1", signature[127:64], 64'h20);
        checkOutput("all_sig2", signature[191:128], 64'h30);

        // clear_i coincident with an accepted last flit while channel 0 is IN_PKT
        data[63:0] = 64'h5;
        applyStimulus(3'b001, 3'b000, 2'd0, 1'b0);
        step();
        checkOutput("cc_busy_pre", 64'(busy), 64'h1);
        checkOutput("cc_flit_pre", 64'(flitCnt[15:0]), 64'd2);
        data[63:0] = 64'h7;
        applyStimulus(3'b001, 3'b001, 2'd0, 1'b1);
        step();
        applyStimulus(3'b000, 3'b000, 2'd0, 1'b0);
        checkOutput("cc_flit", 64'(flitCnt), 64'h0);
        checkOutput("cc_pkt", 64'(pktCnt), 64'h0);
        checkOutput("cc_busy", 64'(busy), 64'h0);
        checkOutput("cc_sig0", signature[63:0], 64'h0);
        checkOutput("cc_ready", 64'(ready), 64'h7);
        checkOutput("main_ovf", 64'(ovf), 64'h0);

        // Saturation with CntWidth=2: four single-flit packets on channel 0
        sValid = 3'b001;
        sLast  = 3'b001;
        for (int k = 0; k < 3; k++) begin
            step();
        end
        checkOutput("sat_flit3", 64'(sFlit[1:0]), 64'd3);
        checkOutput("sat_pkt3", 64'(sPkt[1:0]), 64'd3);
        checkOutput("sat_ovf3", 64'(sOvf), 64'h0);
        step();
        sValid = 3'b000;
        sLast  = 3'b000;
        checkOutput("sat_flit4", 64'(sFlit[1:0]), 64'd3);
        checkOutput("sat_pkt4", 64'(sPkt[1:0]), 64'd3);
        checkOutput("sat_ovf4", 64'(sOvf), 64'h1);
        step();
        checkOutput("sat_ovf_sticky", 64'(sOvf), 64'h1);
        sClear = 1'b1;
        step();
        sClear = 1'b0;
        checkOutput("sat_clr_flit", 64'(sFlit), 64'h0);
        checkOutput("sat_clr_pkt", 64'(sPkt), 64'h0);
        checkOutput("sat_clr_ovf", 64'(sOvf), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
